// File: rtl/conv_pkg.sv
// Shared conv-layer helpers: output geometry, output word width selection and mode constants.
package conv_pkg;

  localparam logic [63:0] MODE_RELU    = "relu";
  localparam logic [63:0] MODE_SIGMOID = "sigmoid";
  localparam logic [63:0] MODE_DEQUANT = "dequant";

  function automatic int unsigned conv_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int unsigned conv_out_dim(input int unsigned in_dim, input int unsigned k,
                                               input int unsigned d, input int unsigned p,
                                               input int unsigned s);
    return (in_dim + 2 * p - d * (k - 1) - 1) / s + 1;
  endfunction

  // relu keeps 8-bit activations; sigmoid and dequant widen to 16 bits.
  function automatic int unsigned conv_ow(input logic [63:0] mode);
    return (mode == MODE_RELU) ? 8 : 16;
  endfunction

endpackage

// File: rtl/conv_result_slot.sv
// Per-PE result slot: tracks an outstanding job, captures its result and flags stray results.
module conv_result_slot #(
  parameter int unsigned RW = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dispatch,
  input  logic          capture_valid,
  input  logic [RW-1:0] capture_data,
  input  logic          collect,
  output logic [RW-1:0] data,
  output logic          full,
  output logic          outstanding,
  output logic          err
);

  logic [RW-1:0] data_q;
  logic          full_q;
  logic          outstanding_q;
  logic          capture;

  // Dispatch needs ~outstanding and capture needs outstanding, so they never collide.
  assign capture = capture_valid & outstanding_q;
  assign err     = capture_valid & ~outstanding_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q        <= '0;
      full_q        <= 1'b0;
      outstanding_q <= 1'b0;
    end else begin
      if (dispatch) begin
        outstanding_q <= 1'b1;
      end else if (capture) begin
        outstanding_q <= 1'b0;
      end
      if (capture) begin
        full_q <= 1'b1;
        data_q <= capture_data;
      end else if (collect) begin
        full_q <= 1'b0;
      end
    end
  end

  assign data        = data_q;
  assign full        = full_q;
  assign outstanding = outstanding_q;

endmodule

// File: rtl/conv_pe_array_ctrl.sv
// Round-robin window dispatch to NUM_PE engines with strictly in-order result collection,
// output backpressure, per-frame pixel counting and weight-write dispatch blocking.
module conv_pe_array_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 256,
  parameter int unsigned IN_HEIGHT   = 256,
  parameter int unsigned KERNEL_0    = 3,
  parameter int unsigned KERNEL_1    = 3,
  parameter int unsigned DILATION_0  = 2,
  parameter int unsigned DILATION_1  = 2,
  parameter int unsigned PADDING_0   = 2,
  parameter int unsigned PADDING_1   = 2,
  parameter int unsigned STRIDE_0    = 1,
  parameter int unsigned STRIDE_1    = 1,
  parameter int unsigned IN_CHANNEL  = 32,
  parameter int unsigned OUT_CHANNEL = 32,
  parameter logic [63:0] OUTPUT_MODE = MODE_RELU,
  parameter int unsigned NUM_PE      = 4,
  localparam int unsigned OW = conv_ow(OUTPUT_MODE),
  localparam int unsigned DW = 8 * IN_CHANNEL * KERNEL_0 * KERNEL_1,
  localparam int unsigned RW = OW * OUT_CHANNEL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_ack,
  output logic [DW-1:0]        pe_i_data,
  output logic [NUM_PE-1:0]    pe_i_valid,
  input  logic [NUM_PE-1:0]    pe_ready_i,
  input  logic [NUM_PE*RW-1:0] pe_o_data,
  input  logic [NUM_PE-1:0]    pe_o_valid,
  output logic [RW-1:0]        o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  input  logic                 weight_wr_en,
  output logic                 o_frame_done,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int unsigned PW = (NUM_PE > 1) ? conv_clog2(NUM_PE) : 1;
  localparam int unsigned OUT_H =
      conv_out_dim(IN_HEIGHT, KERNEL_0, DILATION_0, PADDING_0, STRIDE_0);
  localparam int unsigned OUT_W =
      conv_out_dim(IN_WIDTH, KERNEL_1, DILATION_1, PADDING_1, STRIDE_1);
  localparam int unsigned FRAME_PIX = OUT_H * OUT_W;
  localparam int unsigned CW = (FRAME_PIX > 1) ? conv_clog2(FRAME_PIX) : 1;

  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]     pe_i_data_q;
  logic [NUM_PE-1:0] pe_i_valid_q;
  logic              o_ack_q;
  logic [RW-1:0]     o_data_q;
  logic              o_valid_q;
  logic [CW-1:0]     pix_cnt_q;
  logic              frame_done_q;
  logic              busy_q;
  logic              err_q;

  logic [RW-1:0]     slot_data [NUM_PE];
  logic [NUM_PE-1:0] slot_full;
  logic [NUM_PE-1:0] outstanding;
  logic [NUM_PE-1:0] slot_err;

  logic dispatch, collect, accept, frame_last;

  for (genvar p = 0; p < NUM_PE; p++) begin : g_slot
    conv_result_slot #(
      .RW(RW)
    ) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .dispatch     (dispatch && (wr_ptr_q == PW'(p))),
      .capture_valid(pe_o_valid[p]),
      .capture_data (pe_o_data[p*RW +: RW]),
      .collect      (collect && (rd_ptr_q == PW'(p))),
      .data         (slot_data[p]),
      .full         (slot_full[p]),
      .outstanding  (outstanding[p]),
      .err          (slot_err[p])
    );
  end

  // Never skip a busy PE: keeping dispatch order equal to collect order is what keeps output in order.
  always_comb begin
    o_ready    = rst_n & ~weight_wr_en & pe_ready_i[wr_ptr_q] & ~outstanding[wr_ptr_q] &
                 ~slot_full[wr_ptr_q];
    dispatch   = i_valid & o_ready;
    collect    = slot_full[rd_ptr_q] & (~o_valid_q | i_ready);
    accept     = o_valid_q & i_ready;
    frame_last = accept & (pix_cnt_q == CW'(FRAME_PIX - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pe_i_data_q  <= '0;
      pe_i_valid_q <= '0;
      o_ack_q      <= 1'b0;
      o_data_q     <= '0;
      o_valid_q    <= 1'b0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (dispatch) begin
        pe_i_data_q <= i_data;
        wr_ptr_q    <= (wr_ptr_q == PW'(NUM_PE - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      pe_i_valid_q <= dispatch ? (NUM_PE'(1) << wr_ptr_q) : '0;
      o_ack_q      <= dispatch;

      if (collect) begin
        o_data_q  <= slot_data[rd_ptr_q];
        o_valid_q <= 1'b1;
        rd_ptr_q  <= (rd_ptr_q == PW'(NUM_PE - 1)) ? '0 : rd_ptr_q + 1'b1;
      end else if (i_ready) begin
        o_valid_q <= 1'b0;
      end

      if (accept) begin
        pix_cnt_q <= frame_last ? '0 : pix_cnt_q + 1'b1;
      end
      frame_done_q <= frame_last;
      busy_q       <= (|outstanding) | (|slot_full) | o_valid_q;
      err_q        <= err_q | (|slot_err);
    end
  end

  assign pe_i_data    = pe_i_data_q;
  assign pe_i_valid   = pe_i_valid_q;
  assign o_ack        = o_ack_q;
  assign o_data       = o_data_q;
  assign o_valid      = o_valid_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_conv_pe_array_ctrl.sv
// Scoreboard bench for conv_pe_array_ctrl: behavioural PEs with per-PE latency, 8x8 frame geometry.
module tb_conv_pe_array_ctrl;

  localparam int NP = 4;
  localparam int DW = 72;  // 8 * IN_CHANNEL(1) * 3 * 3
  localparam int RW = 16;  // OW(8, relu) * OUT_CHANNEL(2)
  localparam int FRAME = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   i_data;
  logic            i_valid;
  logic            o_ready, o_ack;
  logic [DW-1:0]   pe_i_data;
  logic [NP-1:0]   pe_i_valid;
  logic [NP-1:0]   pe_ready_i;
  logic [NP*RW-1:0] pe_o_data;
  logic [NP-1:0]   pe_o_valid, model_vld, spur;
  logic [RW-1:0]   o_data;
  logic            o_valid, i_ready, weight_wr_en;
  logic            o_frame_done, o_busy, o_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int fd_cnt = 0;
  bit fd_exp = 1'b0;
  int lat [NP];
  int cnt [NP];
  logic [RW-1:0] exp_q [$];
  logic [NP-1:0] disp_log [$];
  int out_cyc [$];

  always #5 clk = ~clk;

  conv_pe_array_ctrl #(
    .IN_WIDTH   (8),
    .IN_HEIGHT  (8),
    .KERNEL_0   (3),
    .KERNEL_1   (3),
    .DILATION_0 (1),
    .DILATION_1 (1),
    .PADDING_0  (1),
    .PADDING_1  (1),
    .STRIDE_0   (1),
    .STRIDE_1   (1),
    .IN_CHANNEL (1),
    .OUT_CHANNEL(2),
    .NUM_PE     (NP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_ack       (o_ack),
    .pe_i_data   (pe_i_data),
    .pe_i_valid  (pe_i_valid),
    .pe_ready_i  (pe_ready_i),
    .pe_o_data   (pe_o_data),
    .pe_o_valid  (pe_o_valid),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .weight_wr_en(weight_wr_en),
    .o_frame_done(o_frame_done),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  assign pe_o_valid = model_vld | spur;

  // Behavioural PE: result = window[15:0] ^ C3A5, presented lat[p] cycles after pe_i_valid[p].
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) cnt[p] <= 0;
      model_vld <= '0;
      pe_o_data <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        model_vld[p] <= (cnt[p] == 1);
        if (pe_i_valid[p]) begin
          cnt[p] <= lat[p] - 1;
          pe_o_data[p*RW +: RW] <= pe_i_data[15:0] ^ 16'hC3A5;
        end else if (cnt[p] > 0) begin
          cnt[p] <= cnt[p] - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard push on dispatch, pop/compare on accepted output, pulse timing checks.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        acc_cnt = 0;
        fd_exp  = 1'b0;
      end else begin
        if (i_valid && o_ready) exp_q.push_back(i_data[15:0] ^ 16'hC3A5);
        if (pe_i_valid != '0) disp_log.push_back(pe_i_valid);
        if (o_ack || pe_i_valid != '0)
          check("ack_onehot_dispatch", {o_ack, 1'($onehot(pe_i_valid))}, 2'b11);
        if (fd_exp || o_frame_done) check("frame_done", o_frame_done, fd_exp);
        if (o_frame_done) fd_cnt++;
        fd_exp = 1'b0;
        if (o_valid && i_ready) begin
          out_cyc.push_back(cyc);
          acc_cnt++;
          fd_exp = (acc_cnt % FRAME == 0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra_output: got %0h expected none", o_data);
          end else begin
            check("o_data", o_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input int id);
    bit hs;
    int n;
    i_data  = DW'(id) | (DW'(id) << 40);
    i_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      hs = o_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 300);
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL send_timeout: job %0d not accepted, required within 300 cycles", id);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] seq [5];
    logic [RW-1:0] held;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
    weight_wr_en = 1'b0; spur = '0; pe_ready_i = '1;
    for (int p = 0; p < NP; p++) lat[p] = 3;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_ready", o_ready, 0);
    check("rst_o_ack", o_ack, 0);
    check("rst_pe_i_valid", pe_i_valid, 0);
    check("rst_pe_i_data", pe_i_data, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_busy", o_busy, 0);
    check("rst_o_err", o_err, 0);
    check("rst_frame_done", o_frame_done, 0);
    #1 rst_n = 1'b1;

    // Round-robin with uniform latency
    disp_log.delete();
    out_cyc.delete();
    for (int i = 1; i <= 5; i++) send(i);
    i_valid = 1'b0;
    drain();
    check("rr_disp_count", disp_log.size(), 5);
    for (int i = 0; i < 5 && i < disp_log.size(); i++) check("rr_disp_seq", disp_log[i], seq[i]);
    check("rr_out_count", out_cyc.size(), 5);
    if (out_cyc.size() >= 4) check("rr_back_to_back", out_cyc[3] - out_cyc[0], 3);

    // Slow PE1: later results wait in slots, dispatch stalls on PE1 at wrap
    do_reset();
    lat = '{2, 10, 2, 2};
    for (int i = 10; i <= 14; i++) send(i);
    i_data = DW'(15) | (DW'(15) << 40);
    @(negedge clk);
    check("pe1_busy_o_ready", o_ready, 0);
    check("pe1_busy_o_busy", o_busy, 1);
    @(posedge clk);
    #1;
    send(15);
    i_valid = 1'b0;
    drain();

    // Backpressure: output held, slots fill, dispatch stalls
    do_reset();
    lat = '{2, 2, 2, 2};
    i_ready = 1'b0;
    for (int i = 20; i <= 24; i++) send(i);
    @(posedge clk);
    #1;
    i_data = DW'(25) | (DW'(25) << 40);
    held = o_data;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_o_valid", o_valid, 1);
      check("bp_o_data", o_data, held);
      check("bp_o_ready", o_ready, 0);
      check("bp_o_ack", o_ack, 0);
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    send(25);
    i_valid = 1'b0;
    drain();

    // Weight write blocks dispatch; in-flight jobs still finish
    lat = '{6, 6, 6, 6};
    send(30);
    send(31);
    weight_wr_en = 1'b1;
    i_data = DW'(32) | (DW'(32) << 40);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("wr_o_ready", o_ready, 0);
      if (k > 0) check("wr_no_dispatch", pe_i_valid, 0);
    end
    @(posedge clk);
    #1 weight_wr_en = 1'b0;
    send(32);
    i_valid = 1'b0;
    drain();

    // Spurious result from idle PE2
    @(posedge clk);
    #1 spur = 4'b0100;
    @(posedge clk);
    #1 spur = '0;
    @(negedge clk);
    check("err_set", o_err, 1);
    check("err_no_output", o_valid, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("err_sticky", o_err, 1);

    // Reset mid-frame with three jobs in flight
    lat = '{20, 20, 20, 20};
    for (int i = 40; i <= 42; i++) send(i);
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_o_busy", o_busy, 0);
    check("mid_rst_o_err", o_err, 0);
    check("mid_rst_pe_i_valid", pe_i_valid, 0);
    check("mid_rst_o_valid", o_valid, 0);
    check("mid_rst_o_ready", o_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Two full 8x8 frames from a clean counter
    lat = '{3, 3, 3, 3};
    disp_log.delete();
    fd_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) send(100 + i);
    i_valid = 1'b0;
    drain();
    if (disp_log.size() > 0) check("restart_pe0", disp_log[0], 4'b0001);
    check("frame_pix_count", acc_cnt, 2 * FRAME);
    check("frame_done_count", fd_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
